// File: rtl/mux5_rr_scheduler_if.sv
// Handshake bundle between the five source lanes, the scheduler and the shared mux output path.
// The slave side is the scheduler; the master side drives requests, lane data and downstream ready.
interface mux5_rr_scheduler_if #(
    parameter int W = 1
) ();
    logic [4:0]     req;
    logic [5*W-1:0] din;
    logic           dout_ready;
    logic [4:0]     gnt;
    logic [2:0]     sel;
    logic [W-1:0]   dout;
    logic           dout_valid;
    logic           busy;

    modport slave (
        input  req, din, dout_ready,
        output gnt, sel, dout, dout_valid, busy
    );

    modport master (
        output req, din, dout_ready,
        input  gnt, sel, dout, dout_valid, busy
    );
endinterface

// File: rtl/mux5_rr_scheduler.sv
// Round-robin owner of a shared 5:1 mux; each grant is a burst of at most HOLD beats,
// with one idle cycle between grants so the search pointer can advance.
module mux5_rr_scheduler #(
    parameter int W    = 1,
    parameter int HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux5_rr_scheduler_if.slave    bus
);
    localparam int CW = $clog2(HOLD + 1);

    // state | meaning
    // IDLE  | no owner; search req from ptr upward and grant on the next edge
    // GRANT | lane sel owns the mux; beats flow while req[sel] stays high
    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q, state_d;
    logic [2:0]     ptr_q, ptr_d;
    logic [2:0]     sel_q, sel_d;
    logic [4:0]     gnt_q, gnt_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [2:0]     pick;
    logic           found;
    logic [3:0]     idx;
    logic           lane_req;
    logic           valid;
    logic           xfer;

    always_comb begin
        pick  = 3'd0;
        found = 1'b0;
        idx   = 4'd0;
        for (int i = 0; i < 5; i++) begin
            idx = 4'(ptr_q) + 4'(i);
            if (idx > 4'd4) idx = idx - 4'd5;
            if (!found && bus.req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
    end

    assign lane_req = bus.req[sel_q];
    assign valid    = (state_q == GRANT) && lane_req;
    assign xfer     = valid && bus.dout_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    gnt_d   = 5'b00001 << pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                // a dropped request releases even if the downstream is ready
                if (!lane_req || (xfer && cnt_q == CW'(HOLD - 1))) begin
                    state_d = IDLE;
                    gnt_d   = 5'b00000;
                    cnt_d   = '0;
                    ptr_d   = (sel_q == 3'd4) ? 3'd0 : sel_q + 3'd1;
                end else if (xfer) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            sel_q   <= 3'd0;
            gnt_q   <= 5'b00000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.sel        = sel_q;
    assign bus.busy       = (state_q == GRANT);
    assign bus.dout_valid = valid;
    assign bus.dout       = valid ? bus.din[sel_q*W +: W] : '0;
endmodule

// File: doc/mux5_rr_scheduler.md
# mux5_rr_scheduler

- Round-robin scheduler that shares one 5:1 data multiplexer between five requesters.
- Arbitrates among `req[4:0]`, drives the mux select `sel[2:0]` and a one-hot grant, and presents the selected lane's data downstream with a valid/ready handshake.
- Each grant is a bounded burst of at most `HOLD` beats, so no requester can starve the others.
- Sits between the five source lanes and the shared mux output path.

## Interface
- `W`, default 1: data width per lane.
- `HOLD`, default 4: maximum transferred beats per grant; must be ≥1.
- One clock; reset is asynchronous and active-low.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req` in 5: per-lane request, level-sensitive.
- `din` in 5*W: lane data; lane k is `din[k*W +: W]`.
- `dout_ready` in 1: downstream accepts a beat this cycle.
- `gnt` out 5: one-hot grant (all-zero when idle).
- `sel` out 3: mux select, 0..4, registered.
- `dout` out W: selected lane data; forced to 0 when `dout_valid`=0.
- `dout_valid` out 1: beat offered.
- `busy` out 1: high in GRANT state.

## Operation
- Two-state FSM: IDLE, GRANT.
- State registers: `ptr` (3 bits, 0..4) and `cnt` (width clog2(HOLD+1)).
- **Reset:** on `rst_n`=0, registers clear immediately, regardless of the current state:
  - state=IDLE, `ptr`=0, `sel`=0, `gnt`=0, `cnt`=0.
  - Outputs: `dout_valid`=0, `dout`=0, `busy`=0.
- **IDLE:**
  - If `req`≠0, pick the first lane k with `req[k]`=1, searching in order `ptr`, `ptr`+1, …, wrapping 4→0.
  - At the edge, load `sel`=k, `gnt`=1<<k, `cnt`=0, and go to GRANT.
  - If `req`=0, stay in IDLE.
- **GRANT:**
  - `dout_valid` = `req[sel]`.
  - `dout` = `din[sel*W +: W]` when valid, combinational.
  - A beat transfers when `dout_valid`&&`dout_ready`; each transfer increments `cnt`.
- **Release** occurs at the edge where either condition holds:
  - (a) `req[sel]`=0; this releases regardless of `dout_ready`.
  - (b) a transfer occurs with `cnt`==HOLD-1.
- **On release:**
  - Next state IDLE, `gnt`←0, `cnt`←0.
  - `ptr`←(`sel`+1) mod 5, wrapping 4→0.
  - `sel` holds its last value.
- **Stalls:** `dout_ready`=0 with `req[sel]`=1 holds GRANT indefinitely; `cnt` is unchanged.
- **Fixed behaviour:**
  - Requests from non-granted lanes are ignored during GRANT.
  - A requester that drops and re-raises `req` mid-grant loses the grant at the drop.

## Timing
- **Grant latency:** `req` sampled high in IDLE at edge t gives `gnt`/`sel`/`busy` high from edge t; `dout_valid` can be high in the cycle after edge t.
- **Inter-grant gap:** exactly one IDLE cycle between consecutive grants, including a re-grant of the same sole requester.
- **Burst length:** a burst with `dout_ready`=1 throughout delivers HOLD beats in HOLD consecutive cycles, then one idle cycle follows.
- **Output paths:** `dout`/`dout_valid` depend combinationally on `req`, `din` and registered state; `gnt`/`sel`/`busy` are purely registered.
- **Drop with ready high:** if `req[sel]` falls in the same cycle as `dout_ready`=1, no beat transfers and release occurs at that edge.
- **Reset mid-burst:** the partial burst is discarded; the first grant after reset searches from lane 0.

## Test plan
- **Reset:** `rst_n`=0 mid-GRANT (`sel`=3, `cnt`=2) → the same cycle shows `gnt`=0, `dout_valid`=0, `busy`=0; after release, `req`=5'b01000 → grant to lane 3 (`ptr`=0 search).
- **Rotation:** `req`=5'b11111, `dout_ready`=1, HOLD=4, lane k data = k+1 → grants in order 0,1,2,3,4,0. Each grant gives 4 beats with `dout`=k+1, followed by a 1-cycle gap.
- **Wrap:** only lanes 4 and 1 requesting, starting with `ptr`=0 → order 1,4,1,4; `ptr` goes 2, then 0 (wrap), then 2.
- **Backpressure:** lane 2 granted, `dout_ready`=0 for 5 cycles, then 1 → `dout_valid` stays 1 and `cnt` stays 0 during the stall; exactly 4 transfers occur, then release.
- **Early drop:** lane 0 granted; `req[0]` falls after 2 transfers → release at that edge; `dout_valid`=0 in the drop cycle; the next grant goes to the next requesting lane ≥1.
- **HOLD=1, single requester:** `req`=5'b00100 held → `gnt` pattern 00100, 0, 00100, 0…, with exactly one beat per grant.
